// File: rtl/convolver_mc_if.sv
// convolver_mc_if: frame control, activation stream and result bus of convolver_mc
interface convolver_mc_if #(parameter int N = 8, parameter int K = 3, parameter int M = 2);
  logic start, relu_en, act_valid, act_ready, valid_conv, end_conv, busy;
  logic [M*K*K*N-1:0] weights;
  logic [N-1:0] activation;
  logic [M*N-1:0] conv_op;
  modport master(output start, relu_en, weights, act_valid, activation,
                 input act_ready, conv_op, valid_conv, end_conv, busy);
  modport slave(input start, relu_en, weights, act_valid, activation,
                output act_ready, conv_op, valid_conv, end_conv, busy);
endinterface

// File: rtl/convolver_mc.sv
// convolver_mc: streaming multi-channel KxK fixed-point convolution with stride, saturation and optional ReLU
module convolver_mc #(
  parameter int MAP_SIZE = 10,
  parameter int K = 3,
  parameter int S = 1,
  parameter int N = 8,
  parameter int Q = 4,
  parameter int M = 2
) (
  input logic clk,
  input logic global_rst,
  convolver_mc_if.slave bus
);
  localparam int OUT = (MAP_SIZE - K) / S + 1;
  localparam int LAST = K - 1 + (OUT - 1) * S;
  localparam int SW = 2 * N + $clog2(K * K);
  localparam int CW = $clog2(MAP_SIZE);
  localparam logic signed [SW-1:0] MX = SW'((1 << (N - 1)) - 1);
  localparam logic signed [SW-1:0] MN = -MX - 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;
  logic [CW-1:0] row, col;
  logic [N-1:0] lb [K-1][MAP_SIZE];
  logic signed [N-1:0] win [K][K];
  logic signed [N-1:0] wt;
  logic signed [2*N-1:0] p;
  logic signed [SW-1:0] acc_s [M];
  logic signed [SW-1:0] sum [M];
  logic signed [SW-1:0] sh;
  logic [N-1:0] sat;
  logic [M*K*K*N-1:0] w;
  logic [M*N-1:0] res;
  logic relu, seen, v0, l0, v1, l1, acc, hit, last, eol, eof;
  assign bus.act_ready = state == RUN;
  assign bus.busy = state != IDLE;
  assign acc = bus.act_valid && bus.act_ready;
  assign hit = acc && int'(row) >= K - 1 && int'(col) >= K - 1 &&
               (int'(row) - K + 1) % S == 0 && (int'(col) - K + 1) % S == 0;
  assign last = hit && int'(row) == LAST && int'(col) == LAST;
  assign eol = int'(col) == MAP_SIZE - 1;
  assign eof = eol && int'(row) == MAP_SIZE - 1;
  always_comb begin
    wt = '0;
    p = '0;
    for (int m = 0; m < M; m++) begin
      acc_s[m] = '0;
      for (int t = 0; t < K * K; t++) begin
        wt = w[N*(m*K*K+t) +: N];
        p = win[t/K][t%K] * wt;
        acc_s[m] = acc_s[m] + SW'(p);
      end
    end
  end
  always_comb begin
    res = '0;
    sh = '0;
    sat = '0;
    for (int m = 0; m < M; m++) begin
      sh = sum[m] >>> Q;
      sat = sh > MX ? MX[N-1:0] : sh < MN ? MN[N-1:0] : sh[N-1:0];
      res[N*m +: N] = relu && sat[N-1] ? '0 : sat;
    end
  end
  // line buffers hold the previous K-1 rows; the window shifts in one column per accepted beat
  always_ff @(posedge clk) begin
    if (acc) begin
      lb[0][col] <= bus.activation;
      for (int j = 1; j < K - 1; j++) lb[j][col] <= lb[j-1][col];
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K - 1; j++) win[i][j] <= win[i][j+1];
      for (int i = 0; i < K - 1; i++) win[i][K-1] <= lb[K-2-i][col];
      win[K-1][K-1] <= bus.activation;
    end
    if (v0) sum <= acc_s;
  end
  always_ff @(posedge clk) begin
    if (global_rst) begin
      state <= IDLE;
      row <= '0;
      col <= '0;
      {seen, v0, l0, v1, l1} <= '0;
      bus.valid_conv <= 1'b0;
      bus.end_conv <= 1'b0;
      bus.conv_op <= '0;
      relu <= 1'b0;
      w <= '0;
    end else begin
      {v0, l0, v1, l1} <= {hit, last, v0, l0};
      bus.valid_conv <= v1;
      bus.end_conv <= l1;
      if (v1) bus.conv_op <= res;
      seen <= seen || bus.end_conv;
      case (state)
        IDLE: if (bus.start) begin
          w <= bus.weights;
          relu <= bus.relu_en;
          row <= '0;
          col <= '0;
          seen <= 1'b0;
          state <= RUN;
        end
        RUN: if (acc) begin
          col <= eol ? '0 : col + 1'b1;
          if (eol) row <= row + 1'b1;
          if (eof) state <= DRAIN;
        end
        DRAIN: if (bus.end_conv || seen) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_convolver_mc.sv
// tb_convolver_mc: directed frames on a 4x4/S1 and a 5x5/S2 instance, checked by a queued scoreboard
module tb_convolver_mc;
  logic clk = 0, global_rst = 1, start = 0, relu_en = 0, act_valid = 0, sel = 0;
  logic [143:0] weights = '0;
  logic [7:0] activation = '0;
  always #5 clk = ~clk;
  convolver_mc_if #(.N(8), .K(3), .M(2)) ifa();
  convolver_mc_if #(.N(8), .K(3), .M(2)) ifb();
  assign ifa.start = start & ~sel;
  assign ifb.start = start & sel;
  assign ifa.relu_en = relu_en;
  assign ifb.relu_en = relu_en;
  assign ifa.weights = weights;
  assign ifb.weights = weights;
  assign ifa.activation = activation;
  assign ifb.activation = activation;
  assign ifa.act_valid = act_valid & ~sel;
  assign ifb.act_valid = act_valid & sel;
  convolver_mc #(.MAP_SIZE(4), .K(3), .S(1), .N(8), .Q(4), .M(2))
    dut_a (.clk(clk), .global_rst(global_rst), .bus(ifa));
  convolver_mc #(.MAP_SIZE(5), .K(3), .S(2), .N(8), .Q(4), .M(2))
    dut_b (.clk(clk), .global_rst(global_rst), .bus(ifb));
  logic rdy, vconv, econv, busy;
  logic [15:0] conv_op;
  assign rdy = sel ? ifb.act_ready : ifa.act_ready;
  assign vconv = sel ? ifb.valid_conv : ifa.valid_conv;
  assign econv = sel ? ifb.end_conv : ifa.end_conv;
  assign busy = sel ? ifb.busy : ifa.busy;
  assign conv_op = sel ? ifb.conv_op : ifa.conv_op;
  typedef struct { logic [15:0] v; logic last; time t; } exp_t;
  exp_t sb[$];
  exp_t x_d, x_m;
  logic [15:0] tbl[$];
  logic [15:0] held_a = '0, held_b = '0;
  int cmp = 0, fails = 0;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    cmp++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask
  function automatic logic [143:0] wfill(input logic [7:0] a, input logic [7:0] b);
    logic [143:0] v;
    v = '0;
    for (int t = 0; t < 9; t++) begin
      v[8*t +: 8] = a;
      v[8*(9+t) +: 8] = b;
    end
    return v;
  endfunction
  task automatic load4(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
    tbl.push_back(a);
    tbl.push_back(b);
    tbl.push_back(c);
    tbl.push_back(d);
  endtask
  always @(negedge clk) begin
    if (global_rst) begin
      held_a = ifa.conv_op;
      held_b = ifb.conv_op;
    end else begin
      if (!ifa.valid_conv) chk("hold_a", ifa.conv_op, held_a);
      if (!ifb.valid_conv) chk("hold_b", ifb.conv_op, held_b);
      held_a = ifa.conv_op;
      held_b = ifb.conv_op;
    end
    if (vconv) begin
      if (sb.size() == 0) begin
        cmp++;
        fails++;
        $display("FAIL unexpected_pulse: got conv_op %h with no result pending at %0t", conv_op, $time);
      end else begin
        x_m = sb.pop_front();
        chk("conv_op", conv_op, x_m.v);
        chk("end_conv", econv, x_m.last);
        chk("latency", $time, x_m.t);
      end
    end else chk("stray_end", econv, 0);
  end
  task automatic frame(input bit s, input bit r, input logic [143:0] wv, input bit pos,
                       input logic [7:0] cv, input int gap, input int stop,
                       input bit probe, input bit midstart);
    int msz, st, out, n, rr, cc, lim, k;
    bit rd;
    @(negedge clk);
    sel = s;
    msz = s ? 5 : 4;
    st = s ? 2 : 1;
    out = (msz - 3) / st + 1;
    start = 1;
    relu_en = r;
    weights = wv;
    @(negedge clk);
    start = 0;
    chk("busy_after_start", busy, 1);
    n = 0;
    lim = 0;
    while (n < msz * msz && n < stop && lim < 2000) begin
      lim++;
      act_valid = (gap == 0) || ($urandom_range(0, 99) >= gap);
      rr = n / msz;
      cc = n % msz;
      activation = pos ? 8'(rr * 16 + cc) : cv;
      start = midstart && n == 5;
      rd = rdy;
      @(posedge clk);
      if (act_valid && rd) begin
        if (rr >= 2 && cc >= 2 && (rr - 2) % st == 0 && (cc - 2) % st == 0) begin
          if (tbl.size() == 0) begin
            cmp++;
            fails++;
            $display("FAIL table_underrun: got window (%0d,%0d) with no expected entry", rr, cc);
          end else begin
            x_d.v = tbl.pop_front();
            x_d.last = rr == 2 + (out - 1) * st && cc == 2 + (out - 1) * st;
            x_d.t = $time + 25;
            sb.push_back(x_d);
          end
        end
        n++;
      end
      @(negedge clk);
    end
    start = 0;
    act_valid = 0;
    if (lim >= 2000) begin
      cmp++;
      fails++;
      $display("FAIL beat_timeout: got %0d beats accepted, required %0d", n, msz * msz);
    end
    if (n < msz * msz && n >= stop) begin
      global_rst = 1;
      sb.delete();
      tbl.delete();
      @(negedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_ready", rdy, 0);
      chk("rst_valid", vconv, 0);
      chk("rst_end", econv, 0);
      chk("rst_conv_op", conv_op, 0);
      global_rst = 0;
    end else begin
      k = 0;
      while (busy && k < 60) begin
        @(negedge clk);
        k++;
        if (econv && probe) begin
          start = 1;
          @(negedge clk);
          chk("start_on_end_ignored", busy, 0);
          start = 0;
        end
      end
      chk("idle_after_frame", busy, 0);
      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      chk("tbl_consumed", tbl.size(), 0);
    end
  endtask
  initial begin
    logic [143:0] wp;
    repeat (3) @(negedge clk);
    chk("reset_ready", ifa.act_ready, 0);
    chk("reset_busy", ifa.busy, 0);
    chk("reset_valid", ifa.valid_conv, 0);
    chk("reset_end", ifa.end_conv, 0);
    chk("reset_conv_op", ifa.conv_op, 0);
    chk("reset_busy_b", ifb.busy, 0);
    global_rst = 0;
    load4(16'h2412, 16'h2412, 16'h2412, 16'h2412);
    frame(0, 0, wfill(8'h02, 8'h04), 0, 8'h10, 0, 99, 0, 0);
    load4(16'h24EE, 16'h24EE, 16'h24EE, 16'h24EE);
    frame(0, 0, wfill(8'hFE, 8'h04), 0, 8'h10, 0, 99, 0, 0);
    load4(16'h2400, 16'h2400, 16'h2400, 16'h2400);
    frame(0, 1, wfill(8'hFE, 8'h04), 0, 8'h10, 0, 99, 1, 0);
    load4(16'h807F, 16'h807F, 16'h807F, 16'h807F);
    frame(0, 0, wfill(8'h10, 8'hF0), 0, 8'h70, 0, 99, 0, 0);
    wp = '0;
    wp[7:0] = 8'h10;
    wp[8*13 +: 8] = 8'h10;
    load4(16'h1100, 16'h1302, 16'h3120, 16'h3322);
    frame(1, 0, wp, 1, 8'h00, 0, 99, 0, 0);
    load4(16'h1100, 16'h1201, 16'h2110, 16'h2211);
    frame(0, 0, wp, 1, 8'h00, 0, 99, 0, 0);
    load4(16'h1100, 16'h1201, 16'h2110, 16'h2211);
    frame(0, 0, wp, 1, 8'h00, 40, 99, 0, 1);
    frame(0, 0, wfill(8'h02, 8'h04), 0, 8'h10, 0, 7, 0, 0);
    load4(16'h2412, 16'h2412, 16'h2412, 16'h2412);
    frame(0, 0, wfill(8'h02, 8'h04), 0, 8'h10, 0, 11, 0, 0);
    load4(16'h1100, 16'h1201, 16'h2110, 16'h2211);
    frame(0, 0, wp, 1, 8'h00, 0, 99, 0, 0);
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end
endmodule

// File: doc/convolver_mc.md
CONVOLVER_MC -- requirements
Module: convolver_mc

Interface
REQ-001 Parameter MAP_SIZE, default 10: square input map edge length in pixels; SHALL be >= K.
REQ-002 Parameter K, default 3: square kernel edge length; SHALL be >= 2.
REQ-003 Parameter S, default 1: stride, applied identically in row and column; SHALL be >= 1.
REQ-004 Parameter N, default 8: signed two's-complement data and weight width.
REQ-005 Parameter Q, default 4: fractional bits of the fixed-point format.
REQ-006 Parameter M, default 2: number of output channels (kernels), all applied to the same input stream.
REQ-007 clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-008 global_rst  input  1: synchronous, active-high reset.
REQ-009 start  input  1: single-cycle frame start request.
REQ-010 relu_en  input  1: ReLU mode select, sampled when start is accepted.
REQ-011 weights  input  M*K*K*N: kernel m, tap t at bits [N*(m*K*K+t) +: N]; taps in row-major order; sampled when start is accepted.
REQ-012 act_valid  input  1: activation beat valid.
REQ-013 activation  input  N: pixel value, raster order, row 0 first.
REQ-014 act_ready  output  1: block accepts a beat this cycle.
REQ-015 conv_op  output  M*N: channel m result at bits [N*m +: N].
REQ-016 valid_conv  output  1: conv_op holds a new window result this cycle.
REQ-017 end_conv  output  1: coincides with the final valid_conv of the frame.
REQ-018 busy  output  1: high whenever the FSM is not in IDLE.

Function
REQ-019 FSM states SHALL be IDLE, RUN and DRAIN.
REQ-020 In IDLE, start SHALL latch weights and relu_en, clear the row/column counters, and move the FSM to RUN.
REQ-021 act_ready SHALL equal (state == RUN); a beat is accepted only when act_valid && act_ready.
REQ-022 start outside IDLE, and act_valid outside RUN, SHALL be ignored.
REQ-023 The block SHALL keep K-1 line buffers of MAP_SIZE pixels plus a KxK window register; these SHALL advance only on accepted beats, with no fixed timing assumed between beats.
REQ-024 An accepted beat at (row r, col c) SHALL complete a window when r >= K-1, c >= K-1, (r-K+1) % S == 0 and (c-K+1) % S == 0.
REQ-025 Trailing pixels that cannot complete a window SHALL be consumed and SHALL produce no output.
REQ-026 Per window, each channel SHALL compute the sum of K*K full-precision 2N-bit products in a sum wide enough that no intermediate overflow occurs.
REQ-027 The sum SHALL then be arithmetically shifted right by Q (truncating) and saturated to the signed N-bit range [-2^(N-1), 2^(N-1)-1].
REQ-028 If relu_en was latched high, negative saturated results SHALL output as 0.
REQ-029 Latency: for a window-completing beat accepted at edge t, valid_conv and conv_op SHALL be presented in the cycle following edge t+2, independent of act_valid gaps after the beat.
REQ-030 valid_conv SHALL be a single-cycle pulse per window; conv_op SHALL hold its last value when valid_conv is low.
REQ-031 Outputs per frame SHALL be OUT*OUT, where OUT = (MAP_SIZE-K)/S + 1 using integer division.
REQ-032 After the MAP_SIZE*MAP_SIZE-th accepted beat, the FSM SHALL enter DRAIN.
REQ-033 In DRAIN, the FSM SHALL return to IDLE on the cycle end_conv is asserted.
REQ-034 A start on that same cycle SHALL NOT be accepted; it is honoured from IDLE on the next cycle.

Reset
REQ-035 On global_rst, on any cycle including mid-frame, the FSM SHALL go to IDLE and all counters and the pipeline SHALL clear.
REQ-036 Reset values: conv_op = 0, valid_conv = 0, end_conv = 0, act_ready = 0, busy = 0.
REQ-037 No output pulse SHALL be issued for a frame interrupted by reset.

Verification
REQ-038 MAP_SIZE=4, K=3, S=1, N=8, Q=4, M=2; all activations 0x10; ch0 weights 0x02, ch1 weights 0x04 -> 4 pulses, each ch0=0x12 and ch1=0x24; end_conv on the 4th pulse.
REQ-039 Same config, ch0 weights 0xFE; relu_en=0 -> ch0=0xEE; rerun with relu_en=1 -> ch0=0x00.
REQ-040 Activations 0x70, weights 0x10 -> 0x7F; activations 0x70, weights 0xF0 -> 0x80.
REQ-041 MAP_SIZE=5, K=3, S=2 -> exactly 4 pulses, taken from windows at (0,0), (0,2), (2,0), (2,2).
REQ-042 Random act_valid gaps -> results bit-identical to the gap-free run; each pulse arrives 2 edges after its completing beat.
REQ-043 global_rst asserted after 7 beats, then a new start -> no stale pulse; the next frame's results are correct.
